fifo_seq_ctrl: RTL

//  Sequences one line-buffer FIFO (single-port-per-side block-RAM FIFO with rd/wr clr, inc and en controls).
//  Per job: clears both pointers, fills cfg_len words from the upstream loader, then replays them cfg_passes times.
//  The consumer is the systolic PE column, which reuses a feature-map row across kernel rows.

---
 rtl/fifo_seq_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fifo_seq_ctrl.sv
// fifo_seq_ctrl: sequences one line-buffer FIFO per job.
// Each job clears both pointers, fills len words from the loader, then
// replays them passes times to the PE column by rewinding the read pointer.
// Optional macro FIFO_SEQ_CTRL_STALL_CNT_EN enables the stall-cycle counter;
// without it stall_cnt is tied to 0.
module fifo_seq_ctrl #(
  parameter  int FIFO_SIZE = 4608,
  parameter  int PASS_W    = 4,
  localparam int LEN_W     = $clog2(FIFO_SIZE + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic              dst_ready,
  output logic              wr_clr,
  output logic              wr_en,
  output logic              wr_inc,
  output logic              rd_clr,
  output logic              rd_en,
  output logic              rd_inc,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [31:0]       stall_cnt
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(FIFO_SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FILL, S_DRAIN, S_REWIND, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, word_q;
  logic [PASS_W-1:0]   passes_q, pass_q;
  logic                word_last, pass_last, last_rd, accept;

  // Word counter wraps after len words in both FILL and DRAIN.
  assign word_last = (word_q == len_q - 1'b1);
  assign pass_last = (pass_q == passes_q - 1'b1);
  assign accept    = (state_q == S_IDLE) && start;
  assign busy      = (state_q != S_IDLE);

  // State register; an async reset mid-job simply abandons it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and FIFO strobes; en/inc follow the handshake combinationally.
  always_comb begin
    state_d   = state_q;
    src_ready = 1'b0;
    wr_clr    = 1'b0;
    wr_en     = 1'b0;
    wr_inc    = 1'b0;
    rd_clr    = 1'b0;
    rd_en     = 1'b0;
    rd_inc    = 1'b0;
    done      = 1'b0;
    last_rd   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_len == '0 || cfg_passes == '0) state_d = S_DONE;
          else                                   state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        wr_clr  = 1'b1;
        rd_clr  = 1'b1;
        state_d = S_FILL;
      end
      S_FILL: begin
        src_ready = 1'b1;
        wr_en     = src_valid;
        wr_inc    = src_valid;
        if (src_valid && word_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        rd_en   = dst_ready;
        rd_inc  = dst_ready;
        last_rd = dst_ready && word_last && pass_last;
        if (dst_ready && word_last) state_d = pass_last ? S_DONE : S_REWIND;
      end
      S_REWIND: begin
        rd_clr  = 1'b1;
        state_d = S_DRAIN;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Job configuration and word/pass counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      passes_q <= '0;
      word_q   <= '0;
      pass_q   <= '0;
    end else if (accept) begin
      len_q    <= (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
      passes_q <= cfg_passes;
      word_q   <= '0;
      pass_q   <= '0;
    end else begin
      if (wr_en || rd_en) word_q <= word_last ? '0 : word_q + 1'b1;
      if (state_q == S_REWIND) pass_q <= pass_q + 1'b1;
    end
  end

  // FIFO output is registered, so valid/last trail rd_en by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= rd_en;
      out_last  <= last_rd;
    end
  end

`ifdef FIFO_SEQ_CTRL_STALL_CNT_EN
  logic [31:0] stall_q;
  // Saturating count of source/consumer stall cycles, cleared per job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (accept)
      stall_q <= '0;
    else if (((state_q == S_FILL && !src_valid) ||
              (state_q == S_DRAIN && !dst_ready)) && stall_q != '1)
      stall_q <= stall_q + 1'b1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
